// File: rtl/blck_builder_ctrl_pkg.sv
// Shared types and sizing helpers for the block builder controller.
// Imported by the controller and by anything that pairs with it.
package blck_builder_ctrl_pkg;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        PAD  = 2'd1,
        FULL = 2'd2
    } state_t;

    function automatic int nwords(input int bus_size, input int blck_size);
        return blck_size / bus_size;
    endfunction

    // Keep the counter at least one bit wide for single-word blocks.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/blck_builder_ctrl.sv
// Sequences the block builder datapath: fill from the bus, pad to the
// block boundary, then hold the completed block until it is consumed.
module blck_builder_ctrl
    import blck_builder_ctrl_pkg::*;
#(
    parameter int BUS_SIZE  = 32,
    parameter int BLCK_SIZE = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  data_in_valid,
    input  logic                  data_in_last,
    input  logic [BUS_SIZE/8-1:0] data_in_validity,
    output logic                  data_in_ready,
    input  logic                  blck_out_ready,
    output logic                  blck_out_valid,
    output logic                  blck_out_last,
    output logic                  blck_out_padded,
    output logic                  en_update,
    output logic                  en_padding,
    output logic                  flag_cnst_add_done
);

    localparam int NWORDS = nwords(BUS_SIZE, BLCK_SIZE);
    localparam int CNT_W  = cnt_w(NWORDS);
    localparam int VW     = BUS_SIZE / 8;

    localparam logic [VW-1:0]    FULLV   = '1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NWORDS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cst_q, cst_d;
    logic             last_q, last_d;
    logic             pad_q, pad_d;
    logic             partial;

    assign partial = (data_in_validity != FULLV);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
            cnt_q   <= '0;
            cst_q   <= 1'b0;
            last_q  <= 1'b0;
            pad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cst_q   <= cst_d;
            last_q  <= last_d;
            pad_q   <= pad_d;
        end
    end

    always_comb begin
        state_d            = state_q;
        cnt_d              = cnt_q;
        cst_d              = cst_q;
        last_d             = last_q;
        pad_d              = pad_q;
        data_in_ready      = 1'b0;
        blck_out_valid     = 1'b0;
        blck_out_last      = 1'b0;
        blck_out_padded    = 1'b0;
        en_update          = 1'b0;
        en_padding         = 1'b0;
        flag_cnst_add_done = 1'b0;

        // Outputs are forced low for the whole reset, not just after it.
        if (!rst) begin
            unique case (state_q)
                FILL: begin
                    data_in_ready = 1'b1;
                    en_update     = data_in_valid;
                    if (data_in_valid) begin
                        if (cnt_q == CNT_MAX) begin
                            state_d = FULL;
                            last_d  = data_in_last;
                            pad_d   = data_in_last & partial;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                            if (data_in_last) begin
                                state_d = PAD;
                                cst_d   = partial;
                                last_d  = 1'b1;
                                pad_d   = 1'b1;
                            end
                        end
                    end
                end
                PAD: begin
                    en_update          = 1'b1;
                    en_padding         = 1'b1;
                    flag_cnst_add_done = cst_q;
                    cst_d              = 1'b1;
                    if (cnt_q == CNT_MAX) begin
                        state_d = FULL;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                FULL: begin
                    blck_out_valid  = 1'b1;
                    blck_out_last   = last_q;
                    blck_out_padded = pad_q;
                    if (blck_out_ready) begin
                        state_d = FILL;
                        cnt_d   = '0;
                        cst_d   = 1'b0;
                        last_d  = 1'b0;
                        pad_d   = 1'b0;
                    end
                end
                default: begin
                    state_d = FILL;
                    cnt_d   = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_blck_builder_ctrl.sv
// Randomized bench for blck_builder_ctrl against a message-level
// model of how words split into blocks, pad cycles and block flags.
module tb_blck_builder_ctrl;

    localparam int BUS  = 32;
    localparam int BLCK = 256;
    localparam int NW   = BLCK / BUS;
    localparam int VW   = BUS / 8;

    typedef struct {
        int data_w;
        bit last;
        bit padded;
        bit partial;
    } blk_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          data_in_valid = 1'b0;
    logic          data_in_last = 1'b0;
    logic [VW-1:0] data_in_validity = '1;
    logic          data_in_ready;
    logic          blck_out_ready = 1'b0;
    logic          blck_out_valid;
    logic          blck_out_last;
    logic          blck_out_padded;
    logic          en_update;
    logic          en_padding;
    logic          flag_cnst_add_done;

    int   n_checks = 0;
    int   n_fail   = 0;
    blk_t exp_q[$];
    bit   mon_en  = 1'b0;
    bit   pending = 1'b0;
    int   data_seen = 0;
    int   pad_seen  = 0;
    blk_t cur;

    blck_builder_ctrl #(.BUS_SIZE(BUS), .BLCK_SIZE(BLCK)) dut (
        .clk                (clk),
        .rst                (rst),
        .data_in_valid      (data_in_valid),
        .data_in_last       (data_in_last),
        .data_in_validity   (data_in_validity),
        .data_in_ready      (data_in_ready),
        .blck_out_ready     (blck_out_ready),
        .blck_out_valid     (blck_out_valid),
        .blck_out_last      (blck_out_last),
        .blck_out_padded    (blck_out_padded),
        .en_update          (en_update),
        .en_padding         (en_padding),
        .flag_cnst_add_done (flag_cnst_add_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int outs();
        return int'({data_in_ready, blck_out_valid, blck_out_last,
                     blck_out_padded, en_update, en_padding,
                     flag_cnst_add_done});
    endfunction

    // Consumer mostly ready, with occasional stalls.
    initial forever begin
        @(posedge clk);
        #1;
        blck_out_ready = ($urandom_range(0, 3) != 0);
    end

    always @(negedge clk) begin
        if (rst) begin
            data_seen = 0;
            pad_seen  = 0;
            pending   = 1'b0;
        end else if (mon_en) begin
            if (en_update && !en_padding) begin
                check("acc_hs", int'({data_in_valid, data_in_ready}), 3);
                data_seen++;
            end
            if (en_update && en_padding) begin
                if (exp_q.size() == 0) begin
                    check("pad_noexp", 1, 0);
                end else begin
                    check("pad_flag", int'(flag_cnst_add_done),
                          (pad_seen == 0) ? int'(exp_q[0].partial) : 1);
                end
                pad_seen++;
            end
            if (blck_out_valid) begin
                check("full_quiet", int'({data_in_ready, en_update}), 0);
                if (!pending) begin
                    if (exp_q.size() == 0) begin
                        check("blk_noexp", 1, 0);
                    end else begin
                        cur = exp_q.pop_front();
                        check("blk_data", data_seen, cur.data_w);
                        check("blk_pad", pad_seen, NW - cur.data_w);
                    end
                end
                check("blk_last", int'(blck_out_last), int'(cur.last));
                check("blk_padded", int'(blck_out_padded), int'(cur.padded));
                if (blck_out_ready) begin
                    pending   = 1'b0;
                    data_seen = 0;
                    pad_seen  = 0;
                end else begin
                    pending = 1'b1;
                end
            end
        end
    end

    task automatic drive_word(input bit last, input logic [VW-1:0] v);
        int t;
        t = 0;
        data_in_valid    = 1'b1;
        data_in_last     = last;
        data_in_validity = v;
        while (1) begin
            @(negedge clk);
            if (data_in_ready) break;
            t++;
            if (t > 200) begin
                check("hs_timeout", 1, 0);
                break;
            end
        end
        @(posedge clk);
        #1;
        data_in_valid    = 1'b0;
        data_in_last     = 1'b0;
        data_in_validity = '1;
    endtask

    // Model: a message of n words fills ceil(n/NW) blocks; the final
    // block pads up to NW and is flagged padded if short or partial.
    task automatic send_msg(input int n, input logic [VW-1:0] v);
        int   nb;
        blk_t b;
        nb = (n + NW - 1) / NW;
        for (int i = 0; i < nb; i++) begin
            b.data_w  = (n - i * NW < NW) ? (n - i * NW) : NW;
            b.last    = (i == nb - 1);
            b.partial = b.last && (v != '1);
            b.padded  = b.last && ((b.data_w < NW) || b.partial);
            exp_q.push_back(b);
        end
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            drive_word(i == n - 1, (i == n - 1) ? v : '1);
        end
    endtask

    initial begin
        int t;
        int n;
        logic [VW-1:0] v;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_outs", outs(), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_fill_ready", int'(data_in_ready), 1);
        check("rst_no_valid", int'(blck_out_valid), 0);

        drive_word(1'b0, '1);
        drive_word(1'b0, '1);
        drive_word(1'b1, '1);
        @(posedge clk);
        #1;
        check("pad2_active", int'(en_padding), 1);
        rst = 1'b1;
        #1;
        check("midrst_outs", outs(), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("midrst_ready", int'(data_in_ready), 1);
        check("midrst_nopad", int'(en_padding), 0);
        mon_en = 1'b1;

        send_msg(8, 4'b1111);
        send_msg(4, 4'b0011);
        send_msg(5, 4'b1111);
        send_msg(16, 4'b1111);
        send_msg(8, 4'b0001);
        send_msg(1, 4'b0000);
        send_msg(7, 4'b1111);

        for (int k = 0; k < 40; k++) begin
            n = $urandom_range(1, 20);
            v = ($urandom_range(0, 1) != 0) ? 4'b1111
                                            : VW'($urandom_range(0, 15));
            send_msg(n, v);
        end

        t = 0;
        while ((exp_q.size() != 0 || pending) && t < 2000) begin
            @(posedge clk);
            t++;
        end
        check("drain", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
